// File: rtl/route_table_loader_pkg.sv
// Shared constants for the routing-table loader, table reader and crossbar:
// mesh geometry, field widths, direction codes and loader state encoding.
`ifndef NUM_NODES
`define NUM_NODES 9
`endif

package route_table_loader_pkg;

   localparam int unsigned MESH_X    = 3;
   localparam int unsigned NUM_NODES = `NUM_NODES;
   // One extra count so the fill counter can sit at NUM_NODES for the final edge
   localparam int unsigned ADDR_SZ   = $clog2(NUM_NODES + 1);
   localparam int unsigned BITS_DIR  = 3;

   typedef enum logic [BITS_DIR-1:0] {
      DIR_NORTH = 3'd0,
      DIR_EAST  = 3'd1,
      DIR_SOUTH = 3'd2,
      DIR_WEST  = 3'd3,
      DIR_LOCAL = 3'd4
   } dir_e;

   typedef enum logic {
      ST_FILL,
      ST_SERVE
   } state_e;

endpackage

// File: rtl/route_table_loader_if.sv
// Config request port plus routing-table write port of the loader.
interface route_table_loader_if;
   import route_table_loader_pkg::*;

   logic                start;
   logic                cfg_valid;
   logic                cfg_ready;
   logic [ADDR_SZ-1:0]  cfg_addr;
   logic [BITS_DIR-1:0] cfg_dir;
   logic                tbl_wr_en;
   logic [ADDR_SZ-1:0]  tbl_wr_addr;
   logic [BITS_DIR-1:0] tbl_wr_data;
   logic                init_done;
   logic                cfg_err;

   modport master (
      output start, cfg_valid, cfg_addr, cfg_dir,
      input  cfg_ready, tbl_wr_en, tbl_wr_addr, tbl_wr_data, init_done, cfg_err
   );

   modport slave (
      input  start, cfg_valid, cfg_addr, cfg_dir,
      output cfg_ready, tbl_wr_en, tbl_wr_addr, tbl_wr_data, init_done, cfg_err
   );

endinterface

// File: rtl/route_table_loader_xy_route_calc.sv
// Combinational dimension-ordered (X then Y) route from source to destination.
module xy_route_calc
   import route_table_loader_pkg::*;
(
   input  logic [ADDR_SZ-1:0] i_sx,
   input  logic [ADDR_SZ-1:0] i_sy,
   input  logic [ADDR_SZ-1:0] i_dx,
   input  logic [ADDR_SZ-1:0] i_dy,
   output dir_e               o_dir
);

   // Resolve column first, then row, else the packet is home
   always_comb begin
      o_dir = DIR_LOCAL;
      if (i_dx < i_sx)      o_dir = DIR_WEST;
      else if (i_dx > i_sx) o_dir = DIR_EAST;
      else if (i_dy < i_sy) o_dir = DIR_NORTH;
      else if (i_dy > i_sy) o_dir = DIR_SOUTH;
   end

endmodule

// File: rtl/route_table_loader.sv
// Routing-table loader: fills the table with XY routes after reset/start,
// then writes single-entry overrides from the config port.
// Optional macro ROUTE_CFG_CHECK_EN: drop malformed overrides and raise cfg_err.
module route_table_loader #(
   parameter int unsigned NODE_ID   = 0,
   parameter int unsigned MESH_X    = route_table_loader_pkg::MESH_X,
   parameter int unsigned NUM_NODES = route_table_loader_pkg::NUM_NODES
) (
   input logic                 clk,
   input logic                 reset,
   route_table_loader_if.slave bus
);
   import route_table_loader_pkg::*;

   localparam logic [ADDR_SZ-1:0] SX       = ADDR_SZ'(NODE_ID % MESH_X);
   localparam logic [ADDR_SZ-1:0] SY       = ADDR_SZ'(NODE_ID / MESH_X);
   localparam logic [ADDR_SZ-1:0] LAST_X   = ADDR_SZ'(MESH_X - 1);
   localparam logic [ADDR_SZ-1:0] FILL_END = ADDR_SZ'(NUM_NODES);
   localparam logic [ADDR_SZ-1:0] OWN_ADDR = ADDR_SZ'(NODE_ID);

   state_e              r_state, w_state_nxt;
   logic [ADDR_SZ-1:0]  r_cnt, r_x, r_y, w_cnt_nxt, w_x_nxt, w_y_nxt;
   logic                r_wr_en, w_wr_en_nxt;
   logic [ADDR_SZ-1:0]  r_wr_addr, w_wr_addr_nxt;
   logic [BITS_DIR-1:0] r_wr_data, w_wr_data_nxt;
   logic                r_init_done, w_init_done_nxt;
   logic                r_cfg_err, w_cfg_err_nxt;
   dir_e                w_route;
   logic                w_cfg_ready, w_accept, w_fill_last, w_cfg_bad;

   assign w_cfg_ready = (r_state == ST_SERVE) && !bus.start;
   assign w_accept    = w_cfg_ready && bus.cfg_valid;
   assign w_fill_last = (r_cnt == FILL_END);

`ifdef ROUTE_CFG_CHECK_EN
   assign w_cfg_bad = (bus.cfg_addr >= FILL_END) ||
                      (bus.cfg_dir > BITS_DIR'(DIR_LOCAL)) ||
                      ((bus.cfg_dir == BITS_DIR'(DIR_LOCAL)) && (bus.cfg_addr != OWN_ADDR));
`else
   assign w_cfg_bad = 1'b0;
`endif

   xy_route_calc u_route (
      .i_sx  (SX),
      .i_sy  (SY),
      .i_dx  (r_x),
      .i_dy  (r_y),
      .o_dir (w_route)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_FILL;
      else        r_state <= w_state_nxt;
   end

   // Next state: fill runs to completion, start in SERVE re-enters FILL
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_FILL:  if (w_fill_last) w_state_nxt = ST_SERVE;
         ST_SERVE: if (bus.start)   w_state_nxt = ST_FILL;
         default:  w_state_nxt = ST_FILL;
      endcase
   end

   // Next values of counters and registered outputs
   always_comb begin
      w_cnt_nxt       = r_cnt;
      w_x_nxt         = r_x;
      w_y_nxt         = r_y;
      w_wr_en_nxt     = 1'b0;
      w_wr_addr_nxt   = r_wr_addr;
      w_wr_data_nxt   = r_wr_data;
      w_init_done_nxt = r_init_done;
      w_cfg_err_nxt   = r_cfg_err;
      case (r_state)
         ST_FILL: begin
            if (!w_fill_last) begin
               w_wr_en_nxt   = 1'b1;
               w_wr_addr_nxt = r_cnt;
               w_wr_data_nxt = w_route;
               w_cnt_nxt     = r_cnt + 1'b1;
               // x/y track the address so no divide is needed at runtime
               if (r_x == LAST_X) begin
                  w_x_nxt = '0;
                  w_y_nxt = r_y + 1'b1;
               end else begin
                  w_x_nxt = r_x + 1'b1;
               end
            end else begin
               w_init_done_nxt = 1'b1;
               w_cnt_nxt       = '0;
               w_x_nxt         = '0;
               w_y_nxt         = '0;
            end
         end
         ST_SERVE: begin
            if (bus.start) begin
               w_init_done_nxt = 1'b0;
               w_cfg_err_nxt   = 1'b0;
               w_cnt_nxt       = '0;
               w_x_nxt         = '0;
               w_y_nxt         = '0;
            end else if (w_accept) begin
               if (w_cfg_bad) begin
                  w_cfg_err_nxt = 1'b1;
               end else begin
                  w_wr_en_nxt   = 1'b1;
                  w_wr_addr_nxt = bus.cfg_addr;
                  w_wr_data_nxt = bus.cfg_dir;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt       <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_init_done <= 1'b0;
         r_cfg_err   <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_x         <= w_x_nxt;
         r_y         <= w_y_nxt;
         r_wr_en     <= w_wr_en_nxt;
         r_wr_addr   <= w_wr_addr_nxt;
         r_wr_data   <= w_wr_data_nxt;
         r_init_done <= w_init_done_nxt;
         r_cfg_err   <= w_cfg_err_nxt;
      end
   end

   assign bus.cfg_ready   = w_cfg_ready;
   assign bus.tbl_wr_en   = r_wr_en;
   assign bus.tbl_wr_addr = r_wr_addr;
   assign bus.tbl_wr_data = r_wr_data;
   assign bus.init_done   = r_init_done;
   assign bus.cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_route_table_loader.sv
// Scoreboard bench for route_table_loader on nodes 0, 4 and 8 of a 3x3 mesh.
module tb_route_table_loader;
   import route_table_loader_pkg::*;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic                cfg_valid = 1'b0;
   logic [ADDR_SZ-1:0]  cfg_addr = '0;
   logic [BITS_DIR-1:0] cfg_dir = '0;

   int n_chk  = 0;
   int n_pass = 0;
   int q0[$];
   int q4[$];
   int q8[$];

   always #5 clk = ~clk;

   route_table_loader_if if0 ();
   route_table_loader_if if4 ();
   route_table_loader_if if8 ();

   assign if0.start = start;  assign if0.cfg_valid = cfg_valid;
   assign if0.cfg_addr = cfg_addr;  assign if0.cfg_dir = cfg_dir;
   assign if4.start = start;  assign if4.cfg_valid = cfg_valid;
   assign if4.cfg_addr = cfg_addr;  assign if4.cfg_dir = cfg_dir;
   assign if8.start = start;  assign if8.cfg_valid = cfg_valid;
   assign if8.cfg_addr = cfg_addr;  assign if8.cfg_dir = cfg_dir;

   route_table_loader #(.NODE_ID(0)) u_dut0 (.clk(clk), .reset(rst_n), .bus(if0));
   route_table_loader #(.NODE_ID(4)) u_dut4 (.clk(clk), .reset(rst_n), .bus(if4));
   route_table_loader #(.NODE_ID(8)) u_dut8 (.clk(clk), .reset(rst_n), .bus(if8));

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   // Reference XY route computed directly from node ids
   function automatic int route(input int id, input int d);
      int sx, sy, dx, dy;
      sx = id % 3;  sy = id / 3;
      dx = d % 3;   dy = d / 3;
      if (dx < sx) return 3;
      if (dx > sx) return 1;
      if (dy < sy) return 0;
      if (dy > sy) return 2;
      return 4;
   endfunction

   function automatic int enc(input int a, input int d);
      return a * 8 + d;
   endfunction

   task automatic push_fill();
      for (int d = 0; d < 9; d++) begin
         q0.push_back(enc(d, route(0, d)));
         q4.push_back(enc(d, route(4, d)));
         q8.push_back(enc(d, route(8, d)));
      end
   endtask

   task automatic push_all(input int a, input int d);
      q0.push_back(enc(a, d));
      q4.push_back(enc(a, d));
      q8.push_back(enc(a, d));
   endtask

   // Table-write monitors: each strobe pops the next expected {addr,data}
   always @(negedge clk) if (if0.tbl_wr_en) begin
      if (q0.size() == 0) chk("n0_unexp_wr", int'(if0.tbl_wr_en), 0);
      else chk("n0_wr", int'({if0.tbl_wr_addr, if0.tbl_wr_data}), q0.pop_front());
   end
   always @(negedge clk) if (if4.tbl_wr_en) begin
      if (q4.size() == 0) chk("n4_unexp_wr", int'(if4.tbl_wr_en), 0);
      else chk("n4_wr", int'({if4.tbl_wr_addr, if4.tbl_wr_data}), q4.pop_front());
   end
   always @(negedge clk) if (if8.tbl_wr_en) begin
      if (q8.size() == 0) chk("n8_unexp_wr", int'(if8.tbl_wr_en), 0);
      else chk("n8_wr", int'({if8.tbl_wr_addr, if8.tbl_wr_data}), q8.pop_front());
   end

   // Nine consecutive write edges, then init_done on the tenth
   task automatic wait_fill(input int start_at);
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); #1;
         chk("fill_en", int'(if4.tbl_wr_en), 1);
         chk("fill_rdy", int'(if4.cfg_ready), 0);
         chk("fill_done_lo", int'(if4.init_done), 0);
         start = (k == start_at);
      end
      start = 1'b0;
      @(posedge clk); #1;
      chk("fill_end_en", int'(if4.tbl_wr_en), 0);
      chk("n0_init_done", int'(if0.init_done), 1);
      chk("n4_init_done", int'(if4.init_done), 1);
      chk("n8_init_done", int'(if8.init_done), 1);
      chk("serve_rdy", int'(if4.cfg_ready), 1);
   endtask

   task automatic req(input int a, input int d, input int wr);
      cfg_valid = 1'b1;
      cfg_addr  = ADDR_SZ'(a);
      cfg_dir   = BITS_DIR'(d);
      #1;
      chk("req_rdy", int'(if4.cfg_ready), 1);
      if (wr != 0) push_all(a, d);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      chk("req_wr", int'(if4.tbl_wr_en), wr);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      chk("idle_en", int'(if4.tbl_wr_en), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_en", int'(if4.tbl_wr_en), 0);
      chk("rst_addr", int'(if4.tbl_wr_addr), 0);
      chk("rst_data", int'(if4.tbl_wr_data), 0);
      chk("rst_done", int'(if4.init_done), 0);
      chk("rst_rdy", int'(if4.cfg_ready), 0);
      chk("rst_err", int'(if0.cfg_err), 0);

      push_fill();
      @(negedge clk) rst_n = 1'b1;
      wait_fill(0);

      // Single override, then two back-to-back
      req(5, 2, 1);
      idle();
      req(1, 3, 1);
      req(7, 0, 1);
      idle();

      // start and cfg_valid together: start wins, refill; start mid-fill ignored
      start = 1'b1; cfg_valid = 1'b1; cfg_addr = 4'd2; cfg_dir = 3'd1;
      #1;
      chk("start_rdy", int'(if4.cfg_ready), 0);
      push_fill();
      @(posedge clk); #1;
      start = 1'b0; cfg_valid = 1'b0;
      chk("start_done_lo", int'(if4.init_done), 0);
      chk("start_en", int'(if4.tbl_wr_en), 0);
      wait_fill(3);

      // Reset after four fill writes
      start = 1'b1;
      push_fill();
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         chk("pre_rst_en", int'(if4.tbl_wr_en), 1);
      end
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_en", int'(if4.tbl_wr_en), 0);
      chk("async_addr", int'(if4.tbl_wr_addr), 0);
      chk("async_data", int'(if4.tbl_wr_data), 0);
      chk("left_after_rst", q4.size(), 5);
      q0.delete(); q4.delete(); q8.delete();
      push_fill();
      @(negedge clk) rst_n = 1'b1;
      wait_fill(0);

`ifdef ROUTE_CFG_CHECK_EN
      req(9, 1, 0);
      chk("err_addr", int'(if0.cfg_err), 1);
      req(3, 4, 0);
      req(3, 1, 1);
      chk("err_sticky", int'(if0.cfg_err), 1);
      start = 1'b1;
      push_fill();
      @(posedge clk); #1;
      start = 1'b0;
      chk("err_clr", int'(if0.cfg_err), 0);
      wait_fill(0);
`else
      req(3, 4, 1);
      chk("err_tied", int'(if0.cfg_err), 0);
      req(8, 1, 1);
      idle();
`endif

      @(posedge clk); #1;
      chk("n0_q_empty", q0.size(), 0);
      chk("n4_q_empty", q4.size(), 0);
      chk("n8_q_empty", q8.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
